// File: rtl/inject_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// inject_scheduler: round-robin share of one router injection port between
// NUM_SRC sources, with packet locking and per-VC credit flow control.
// Revision: 1.0
// ----------------------------------------------------------------------------
module inject_scheduler #(
    parameter int NUM_SRC = 4,
    parameter int VC_BITS = 1,
    parameter int FLIT_W  = 16,
    parameter int CREDITS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SRC-1:0]           src_valid,
    input  logic [NUM_SRC*FLIT_W-1:0]    src_flit,
    input  logic [NUM_SRC*VC_BITS-1:0]   src_vc,
    input  logic [NUM_SRC-1:0]           src_head,
    input  logic [NUM_SRC-1:0]           src_tail,
    output logic [NUM_SRC-1:0]           src_deq,
    output logic                         out_valid,
    output logic [FLIT_W-1:0]            out_flit,
    output logic [VC_BITS-1:0]           out_vc,
    input  logic                         credit_valid,
    input  logic [VC_BITS-1:0]           credit_vc,
    output logic                         locked,
    output logic                         cred_err
);

    localparam int NUM_VC = 2**VC_BITS;
    localparam int CW     = $clog2(CREDITS + 1);
    localparam int PW     = $clog2(NUM_SRC);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [PW-1:0]       owner, owner_nxt;
    logic [PW-1:0]       rr_ptr, rr_nxt;
    logic [PW-1:0]       grant_idx;
    logic [PW-1:0]       cand;
    logic                grant;
    logic [CW-1:0]       credit   [NUM_VC];
    logic [FLIT_W-1:0]   flit_arr [NUM_SRC];
    logic [VC_BITS-1:0]  vc_arr   [NUM_SRC];
    logic [NUM_SRC-1:0]  elig;
    logic [NUM_VC-1:0]   send_vc;
    logic [NUM_VC-1:0]   ret_vc;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            flit_arr[i] = src_flit[i*FLIT_W +: FLIT_W];
            vc_arr[i]   = src_vc[i*VC_BITS +: VC_BITS];
            elig[i]     = src_valid[i] && (credit[vc_arr[i]] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        grant     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        case (state)
            IDLE: begin
                // Only head flits may open a packet; stray body flits are ignored.
                for (int k = 0; k < NUM_SRC; k++) begin
                    cand = PW'((int'(rr_ptr) + k) % NUM_SRC);
                    if (!grant && elig[cand] && src_head[cand]) begin
                        grant     = 1'b1;
                        grant_idx = cand;
                    end
                end
                if (grant) begin
                    rr_nxt = (grant_idx == PW'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
                    if (!src_tail[grant_idx]) begin
                        state_nxt = LOCKED;
                        owner_nxt = grant_idx;
                    end
                end
            end
            LOCKED: begin
                if (elig[owner]) begin
                    grant     = 1'b1;
                    grant_idx = owner;
                    if (src_tail[owner]) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        src_deq = (grant && rst_n) ? (NUM_SRC'(1) << grant_idx) : '0;
    end

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            send_vc[v] = grant && (vc_arr[grant_idx] == VC_BITS'(v));
            ret_vc[v]  = credit_valid && (credit_vc == VC_BITS'(v));
        end
    end

    // A send and a return on the same VC cancel, so that case never overflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                credit[v] <= CW'(CREDITS);
            end
            cred_err <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (ret_vc[v] && !send_vc[v]) begin
                    if (credit[v] == CW'(CREDITS)) begin
                        cred_err <= 1'b1;
                    end else begin
                        credit[v] <= credit[v] + 1'b1;
                    end
                end else if (send_vc[v] && !ret_vc[v]) begin
                    credit[v] <= credit[v] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_flit  <= '0;
            out_vc    <= '0;
        end else begin
            out_valid <= grant;
            if (grant) begin
                out_flit <= flit_arr[grant_idx];
                out_vc   <= vc_arr[grant_idx];
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_inject_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_inject_scheduler: directed self-checking bench for inject_scheduler.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_inject_scheduler;

    localparam int NS = 4;
    localparam int VB = 1;
    localparam int FW = 16;
    localparam int CR = 4;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [NS-1:0]     valid;
    logic [NS-1:0]     head;
    logic [NS-1:0]     tail;
    logic [NS-1:0]     vcs;
    logic [FW-1:0]     flits [NS];
    logic [NS*FW-1:0]  src_flit;
    logic              credit_valid;
    logic [VB-1:0]     credit_vc;
    logic [NS-1:0]     src_deq;
    logic              out_valid;
    logic [FW-1:0]     out_flit;
    logic [VB-1:0]     out_vc;
    logic              locked;
    logic              cred_err;

    int compared   = 0;
    int mismatched = 0;

    assign src_flit = {flits[3], flits[2], flits[1], flits[0]};

    inject_scheduler #(
        .NUM_SRC (NS),
        .VC_BITS (VB),
        .FLIT_W  (FW),
        .CREDITS (CR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_valid    (valid),
        .src_flit     (src_flit),
        .src_vc       (vcs),
        .src_head     (head),
        .src_tail     (tail),
        .src_deq      (src_deq),
        .out_valid    (out_valid),
        .out_flit     (out_flit),
        .out_vc       (out_vc),
        .credit_valid (credit_valid),
        .credit_vc    (credit_vc),
        .locked       (locked),
        .cred_err     (cred_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic src(input int i, input logic v, input logic h, input logic t,
                       input logic c, input logic [FW-1:0] f);
        valid[i] = v;
        head[i]  = h;
        tail[i]  = t;
        vcs[i]   = c;
        flits[i] = f;
    endtask

    task automatic clr();
        valid        = '0;
        head         = '0;
        tail         = '0;
        vcs          = '0;
        for (int i = 0; i < NS; i++) flits[i] = '0;
        credit_valid = 1'b0;
        credit_vc    = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values and alternating single-flit grants
        clr();
        rst_n = 1'b0;
        src(0, 1, 1, 1, 0, 16'h0A00);
        src(2, 1, 1, 1, 1, 16'h2A00);
        @(posedge clk); #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_flit",  out_flit,  0);
        chk("rst_out_vc",    out_vc,    0);
        chk("rst_locked",    locked,    0);
        chk("rst_cred_err",  cred_err,  0);
        chk("rst_deq",       src_deq,   0);
        @(posedge clk); #1; rst_n = 1'b1; #1;
        chk("rr_c1_deq",   src_deq,   4'b0001);
        chk("rr_c1_valid", out_valid, 0);
        tick(); src(0, 1, 1, 1, 0, 16'h0A01); #1;
        chk("rr_c2_deq",   src_deq,   4'b0100);
        chk("rr_c2_valid", out_valid, 1);
        chk("rr_c2_flit",  out_flit,  16'h0A00);
        chk("rr_c2_vc",    out_vc,    0);
        chk("rr_c2_lock",  locked,    0);
        tick(); src(2, 1, 1, 1, 1, 16'h2A01); #1;
        chk("rr_c3_deq",  src_deq,  4'b0001);
        chk("rr_c3_flit", out_flit, 16'h2A00);
        chk("rr_c3_vc",   out_vc,   1);
        tick(); src(0, 1, 1, 1, 0, 16'h0A02); #1;
        chk("rr_c4_deq",  src_deq,  4'b0100);
        chk("rr_c4_flit", out_flit, 16'h0A01);
        chk("rr_c4_lock", locked,   0);

        // Packet lock: source 1 three-flit packet, source 3 waits with a head
        do_reset();
        src(1, 1, 1, 0, 0, 16'h1B00);
        src(3, 1, 1, 1, 1, 16'h3B00); #1;
        chk("pk_c1_deq",  src_deq, 4'b0010);
        chk("pk_c1_lock", locked,  0);
        tick(); src(1, 1, 0, 0, 0, 16'h1B01); #1;
        chk("pk_c2_deq",  src_deq,  4'b0010);
        chk("pk_c2_lock", locked,   1);
        chk("pk_c2_flit", out_flit, 16'h1B00);
        tick(); src(1, 1, 0, 1, 0, 16'h1B02); #1;
        chk("pk_c3_deq",  src_deq,  4'b0010);
        chk("pk_c3_flit", out_flit, 16'h1B01);
        tick(); src(1, 0, 0, 0, 0, 16'h0000); #1;
        chk("pk_c4_deq",  src_deq,  4'b1000);
        chk("pk_c4_lock", locked,   0);
        chk("pk_c4_flit", out_flit, 16'h1B02);
        tick(); src(3, 0, 0, 0, 0, 16'h0000); src(0, 1, 0, 0, 0, 16'h0E00); #1;
        chk("pk_nohead_deq", src_deq,  4'b0000);
        chk("pk_c5_flit",    out_flit, 16'h3B00);
        chk("pk_c5_vc",      out_vc,   1);

        // Credit exhaustion on VC0 with the lock held
        do_reset();
        src(0, 1, 1, 0, 0, 16'h0C00);
        src(1, 1, 1, 1, 1, 16'h1C00); #1;
        chk("cx_c1_deq", src_deq, 4'b0001);
        tick(); src(0, 1, 0, 0, 0, 16'h0C01); #1;
        chk("cx_c2_deq", src_deq, 4'b0001);
        tick(); src(0, 1, 0, 0, 0, 16'h0C02); #1;
        chk("cx_c3_deq", src_deq, 4'b0001);
        tick(); src(0, 1, 0, 0, 0, 16'h0C03); #1;
        chk("cx_c4_deq", src_deq, 4'b0001);
        tick(); src(0, 1, 0, 0, 0, 16'h0C04); credit_valid = 1'b1; credit_vc = 1'b0; #1;
        chk("cx_stall_deq",  src_deq,  4'b0000);
        chk("cx_stall_lock", locked,   1);
        chk("cx_c5_flit",    out_flit, 16'h0C03);
        tick(); credit_valid = 1'b0; #1;
        chk("cx_ret_deq",   src_deq,   4'b0001);
        chk("cx_c6_valid",  out_valid, 0);
        tick(); src(0, 1, 0, 1, 0, 16'h0C05); credit_valid = 1'b1; #1;
        chk("cx_c7_deq",   src_deq,   4'b0000);
        chk("cx_c7_valid", out_valid, 1);
        chk("cx_c7_flit",  out_flit,  16'h0C04);
        tick(); credit_valid = 1'b0; #1;
        chk("cx_tail_deq",  src_deq, 4'b0001);
        chk("cx_tail_lock", locked,  1);
        tick(); src(0, 0, 0, 0, 0, 16'h0000); #1;
        chk("cx_next_deq",  src_deq,  4'b0010);
        chk("cx_next_lock", locked,   0);
        chk("cx_next_flit", out_flit, 16'h0C05);

        // Simultaneous send and return on VC1 leaves the counter at CREDITS
        do_reset();
        src(2, 1, 1, 1, 1, 16'h2D00);
        credit_valid = 1'b1; credit_vc = 1'b1; #1;
        chk("sr_c1_deq", src_deq, 4'b0100);
        tick(); #1;
        chk("sr_c2_deq", src_deq, 4'b0100);
        chk("sr_c2_vc",  out_vc,  1);
        tick(); credit_valid = 1'b0; #1;
        chk("sr_c3_deq", src_deq, 4'b0100);
        tick(); #1;
        chk("sr_c4_deq", src_deq, 4'b0100);
        tick(); #1;
        chk("sr_c5_deq", src_deq, 4'b0100);
        tick(); #1;
        chk("sr_c6_deq", src_deq, 4'b0100);
        tick(); #1;
        chk("sr_c7_deq", src_deq,  4'b0000);
        chk("sr_err",    cred_err, 0);

        // Overflow: return at CREDITS sets sticky error, counter saturates
        do_reset();
        credit_valid = 1'b1; credit_vc = 1'b0; #1;
        chk("ov_pre_err", cred_err, 0);
        tick(); credit_valid = 1'b0; src(0, 1, 1, 1, 0, 16'h0F00); #1;
        chk("ov_err_set", cred_err, 1);
        chk("ov_c2_deq",  src_deq,  4'b0001);
        tick(); #1;
        chk("ov_c3_deq", src_deq, 4'b0001);
        tick(); #1;
        chk("ov_c4_deq", src_deq, 4'b0001);
        tick(); #1;
        chk("ov_c5_deq", src_deq, 4'b0001);
        tick(); #1;
        chk("ov_sat_deq",  src_deq,  4'b0000);
        chk("ov_err_hold", cred_err, 1);

        // Asynchronous reset in the middle of a packet
        do_reset();
        src(1, 1, 1, 0, 0, 16'h1E00); #1;
        chk("ar_c1_deq", src_deq, 4'b0010);
        tick(); src(1, 1, 0, 0, 0, 16'h1E01); #1;
        chk("ar_c2_deq",  src_deq, 4'b0010);
        chk("ar_c2_lock", locked,  1);
        tick(); src(1, 1, 0, 0, 0, 16'h1E02); #1;
        chk("ar_c3_valid", out_valid, 1);
        #2; rst_n = 1'b0; #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_flit",  out_flit,  0);
        chk("ar_vc",    out_vc,    0);
        chk("ar_lock",  locked,    0);
        chk("ar_deq",   src_deq,   0);
        src(1, 0, 0, 0, 0, 16'h0000);
        src(0, 1, 1, 1, 0, 16'h0E10);
        src(3, 1, 1, 1, 1, 16'h3E10);
        @(posedge clk); #1; rst_n = 1'b1; #1;
        chk("ar_rr0_deq", src_deq, 4'b0001);
        tick(); src(0, 0, 0, 0, 0, 16'h0000); #1;
        chk("ar_out_flit",  out_flit,  16'h0E10);
        chk("ar_out_valid", out_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inject_scheduler.md
# inject_scheduler

Shares one router injection port between `NUM_SRC` traffic generators. Each cycle it picks a source by round-robin, issues that source's dequeue strobe, and forwards the flit with its VC onto the router input. Flow control uses per-VC credit counters. A multi-flit packet holds the port from head to tail, so flits from different packets never interleave on the link. The block sits between the traffic-generator array and the local input port of the router in each NoC node.

## Interface
- `NUM_SRC`, default 4: number of traffic sources (2..8).
- `VC_BITS`, default 1: VC index width; VC count is `2**VC_BITS`.
- `FLIT_W`, default 16: flit payload width.
- `CREDITS`, default 4: downstream buffer depth per VC; also the credit counter reset value.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `src_valid` in `NUM_SRC`: source has a flit ready.
- `src_flit` in `NUM_SRC*FLIT_W`: flit of each source; source i occupies slice `[i*FLIT_W +: FLIT_W]`.
- `src_vc` in `NUM_SRC*VC_BITS`: target VC of each source.
- `src_head` in `NUM_SRC`: current flit is a head flit.
- `src_tail` in `NUM_SRC`: current flit is a tail flit (head and tail both set = single-flit packet).
- `src_deq` out `NUM_SRC`: one-hot dequeue strobe; the source advances to its next flit on this edge.
- `out_valid` out 1: flit valid on the router link.
- `out_flit` out `FLIT_W`: forwarded flit.
- `out_vc` out `VC_BITS`: VC of the forwarded flit.
- `credit_valid` in 1: router freed one buffer slot.
- `credit_vc` in `VC_BITS`: VC of the returned credit.
- `locked` out 1: a packet is in progress.
- `cred_err` out 1: sticky; a credit was returned to a counter already at `CREDITS`.

## Operation
- **State machine:** two states, IDLE and LOCKED. Registers: `owner` (source index), `rr_ptr`, one credit counter per VC (width `clog2(CREDITS+1)`).
- **Eligibility:** source i is eligible when `src_valid[i]` = 1 and `credit[src_vc[i]]` > 0.
- **IDLE:**
  - Round-robin search over eligible sources that present a head flit, starting at `rr_ptr`.
  - On a winner w: assert `src_deq[w]` and capture its flit and VC.
  - `rr_ptr` <= w+1 mod `NUM_SRC`.
  - If the flit is not a tail, go to LOCKED with `owner` = w.
  - A source with valid=1 and head=0 in IDLE is a protocol violation. It is ignored and never granted.
- **LOCKED:**
  - Only `owner` is considered. If it is eligible, dequeue it and forward the flit.
  - A flit with the tail bit set returns the block to IDLE.
  - Head flits from other sources wait.
  - The VC is taken from `src_vc[owner]` each flit; sources hold VC constant within a packet.
- **Credits:**
  - Decrement on each forwarded flit; increment on `credit_valid`.
  - Send and return on the same VC in the same cycle leave the counter unchanged.
  - Increment at `CREDITS` saturates and sets `cred_err`; `cred_err` is cleared only by reset.
  - Credit reaching 0 stalls that VC. The lock is kept and no other source is granted.
- **`src_deq`:** at most one bit is set per cycle; it is never set for a source with `src_valid` = 0.

## Timing
- **Grant path:** `src_deq` is combinational from registered state, `src_valid`/`src_head`/`src_vc`, and credit registers. It is not a function of `credit_valid` in the same cycle: a credit returned in cycle t is usable from cycle t+1.
- **Latency:** grant in cycle t registers `out_flit`/`out_vc` at the end of t; `out_valid` = 1 during t+1. One flit per cycle peak throughput.
- **Tail:** LOCKED -> IDLE on the edge that forwards the tail; a new head may be granted in the next cycle.
- **Reset values:** `out_valid` 0, `out_flit` 0, `out_vc` 0, `src_deq` 0, `locked` 0, `cred_err` 0, state IDLE, `rr_ptr` 0, every credit counter = `CREDITS`.
- **Reset mid-packet:** the lock is abandoned and credits return to `CREDITS`. Sources and router are reset by the same `rst_n`.
- **Wrap-around:** `rr_ptr` wraps from `NUM_SRC-1` to 0; a winner at `NUM_SRC-1` sets `rr_ptr` to 0.

## Test plan
- **Reset:** sources 0 and 2 valid with single-flit packets. Grants go 0, 2, 0, 2 on consecutive cycles; `out_valid` first rises in cycle 2 after `rst_n` deasserts; `locked` stays 0.
- **Packet lock:** source 1 sends a 3-flit packet while source 3 holds a head. Flits H, B, T from source 1 appear back-to-back; source 3 is granted the cycle after T.
- **Credit exhaustion:** `CREDITS`=4, VC0, no returns. Four flits are forwarded, then a stall with `locked`=1. One credit on VC0 in cycle t gives a grant in cycle t+1.
- **Simultaneous send and return:** forward on VC1 while `credit_valid` with `credit_vc`=1. `credit[1]` is unchanged.
- **Overflow:** return a credit with the counter at 4. `cred_err` = 1 and stays set; counter stays at 4.
- **Async reset mid-packet:** pull `rst_n` low in the middle of the packet, asynchronous to `clk`. All outputs go to reset values immediately; after release a new head is granted from `rr_ptr` = 0.
